lcd_write_arbiter: RTL

- Shares the single character-LCD write controller (8-bit data / RS / Start / Done handshake) between two requesters, A and B.
- Example pairing: the power-up/static text sequencer on A and a runtime status writer on B.
- Per grant, performs one complete LCD write: issue, wait for Done, settle delay, then acknowledge the winner.
- Supports round-robin fairness, a burst lock so one requester can issue an address command plus a string without interleaving, and a Done timeout.

---
 rtl/lcd_write_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lcd_write_arbiter.sv
// Two-requester arbiter in front of a single character-LCD write controller:
// round-robin grants, optional burst lock per requester, and a Done timeout.
module lcd_write_arbiter #(
   parameter int unsigned DLY   = 262143,
   parameter int unsigned TMO   = 1000000,
   parameter int unsigned CNT_W = 20
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iREQ_A,
   input  logic       iRS_A,
   input  logic [7:0] iDATA_A,
   input  logic       iLOCK_A,
   output logic       oACK_A,
   output logic       oERR_A,
   input  logic       iREQ_B,
   input  logic       iRS_B,
   input  logic [7:0] iDATA_B,
   input  logic       iLOCK_B,
   output logic       oACK_B,
   output logic       oERR_B,
   output logic [7:0] mLCD_DATA,
   output logic       mLCD_RS,
   output logic       mLCD_Start,
   input  logic       mLCD_Done,
   output logic       oBUSY,
   output logic       oOWNER
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_SETTLE, S_ACK} state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             lock_q, lock_d;
   logic             err_q, err_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             grant, win;

   // While locked only the lock holder (always the last grantee) may win.
   always_comb begin
      grant = 1'b0;
      win   = 1'b0;
      if (lock_q) begin
         grant = owner_q ? iREQ_B : iREQ_A;
         win   = owner_q;
      end else if (iREQ_A && iREQ_B) begin
         grant = 1'b1;
         win   = ~last_q;
      end else if (iREQ_A) begin
         grant = 1'b1;
         win   = 1'b0;
      end else if (iREQ_B) begin
         grant = 1'b1;
         win   = 1'b1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      lock_d  = lock_q;
      err_d   = err_q;
      rs_d    = rs_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               owner_d = win;
               rs_d    = win ? iRS_B : iRS_A;
               data_d  = win ? iDATA_B : iDATA_A;
               cnt_d   = '0;
               state_d = S_WAIT_DONE;
            end else if (lock_q && !(owner_q ? (iREQ_B || iLOCK_B) : (iREQ_A || iLOCK_A))) begin
               lock_d = 1'b0;
            end
         end
         S_WAIT_DONE: begin
            if (mLCD_Done) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q == DLY_LAST) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ACK: begin
            last_d  = owner_q;
            lock_d  = owner_q ? iLOCK_B : iLOCK_A;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mLCD_Start = (state_q == S_WAIT_DONE);
      mLCD_RS    = rs_q;
      mLCD_DATA  = data_q;
      oACK_A     = (state_q == S_ACK) && !owner_q;
      oACK_B     = (state_q == S_ACK) && owner_q;
      oERR_A     = oACK_A && err_q;
      oERR_B     = oACK_B && err_q;
      oBUSY      = (state_q != S_IDLE);
      oOWNER     = owner_q;
   end

endmodule
